// File: rtl/idma_inst64_chan_decoder.sv
// iDMA 64-bit instruction decoder: per-channel configuration registers, one-hot copy launch,
// status reads and per-channel transfer-ID bookkeeping behind an accelerator handshake.
module idma_inst64_chan_decoder #(
    parameter int unsigned AddrWidth   = 48,
    parameter int unsigned NumChannels = 2,
    parameter int unsigned IdWidth     = 32
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   acc_req_valid_i,
    output logic                   acc_req_ready_o,
    input  logic [31:0]            acc_req_op_i,
    input  logic [63:0]            acc_req_arga_i,
    input  logic [63:0]            acc_req_argb_i,
    input  logic [4:0]             acc_req_id_i,
    output logic                   acc_rsp_valid_o,
    input  logic                   acc_rsp_ready_i,
    output logic [63:0]            acc_rsp_data_o,
    output logic [4:0]             acc_rsp_id_o,
    output logic                   acc_rsp_error_o,
    output logic [NumChannels-1:0] xfer_valid_o,
    input  logic [NumChannels-1:0] xfer_ready_i,
    output logic [AddrWidth-1:0]   xfer_src_o,
    output logic [AddrWidth-1:0]   xfer_dst_o,
    output logic [63:0]            xfer_len_o,
    output logic [63:0]            xfer_src_stride_o,
    output logic [63:0]            xfer_dst_stride_o,
    output logic [63:0]            xfer_reps_o,
    output logic [63:0]            xfer_user_o,
    output logic                   xfer_2d_o,
    input  logic [NumChannels-1:0] done_i,
    output logic                   busy_o
);
    localparam logic [6:0] OpcodeDma = 7'b0101011;
    localparam logic [6:0] FnSrc = 7'd0, FnDst = 7'd1, FnCpyi = 7'd2, FnCpy = 7'd3;
    localparam logic [6:0] FnStati = 7'd4, FnStat = 7'd5, FnStr = 7'd6, FnRep = 7'd7;
    localparam logic [6:0] FnUser = 7'd8;

    typedef enum logic [1:0] {StIdle, StLaunch, StResp} state_e;

    state_e                 state_q;
    logic [NumChannels-1:0] xfer_valid_q;
    logic [AddrWidth-1:0]   xfer_src_q, xfer_dst_q;
    logic [63:0]            xfer_len_q, xfer_sstr_q, xfer_dstr_q, xfer_reps_q, xfer_user_q;
    logic                   xfer_2d_q;
    logic [63:0]            rsp_data_q;
    logic [4:0]             rsp_id_q;
    logic                   rsp_error_q;

    logic [AddrWidth-1:0] src_q [NumChannels];
    logic [AddrWidth-1:0] dst_q [NumChannels];
    logic [63:0]          src_stride_q [NumChannels];
    logic [63:0]          dst_stride_q [NumChannels];
    logic [63:0]          reps_q [NumChannels];
    logic [63:0]          user_q [NumChannels];
    logic [IdWidth-1:0]   next_id_q [NumChannels];
    logic [IdWidth-1:0]   completed_id_q [NumChannels];
    logic [IdWidth-1:0]   outstanding [NumChannels];
    logic [NumChannels-1:0] busy_vec;

    logic [6:0]             funct7;
    logic [2:0]             chan;
    logic [4:0]             sub;
    logic                   legal, accept, launch_fire;
    logic [NumChannels-1:0] chan_oh;
    logic [AddrWidth-1:0]   sel_src, sel_dst;
    logic [63:0]            sel_sstr, sel_dstr, sel_reps, sel_user, stat_data;
    logic [IdWidth-1:0]     sel_next, sel_comp, launch_id;
    logic                   sel_busy;
    logic                   unused_op;

    assign funct7      = acc_req_op_i[31:25];
    assign chan        = acc_req_op_i[14:12];
    assign legal       = (acc_req_op_i[6:0] == OpcodeDma) && (funct7 <= FnUser) &&
                         (32'(chan) < NumChannels);
    assign accept      = (state_q == StIdle) && acc_req_valid_i;
    assign launch_fire = (state_q == StLaunch) && |(xfer_valid_q & xfer_ready_i);
    // Immediate forms carry the sub-field in rs2's slot, register forms in argb.
    assign sub         = (funct7 == FnCpyi || funct7 == FnStati) ? acc_req_op_i[24:20]
                                                                  : acc_req_argb_i[4:0];
    assign unused_op   = ^{acc_req_op_i[19:15], acc_req_op_i[11:7]};

    for (genvar c = 0; c < NumChannels; c++) begin : g_out
        assign outstanding[c] = next_id_q[c] - completed_id_q[c];
        assign busy_vec[c]    = outstanding[c] != '0;
    end

    always_comb begin
        chan_oh   = '0;
        sel_src   = '0;
        sel_dst   = '0;
        sel_sstr  = '0;
        sel_dstr  = '0;
        sel_reps  = '0;
        sel_user  = '0;
        sel_next  = '0;
        sel_comp  = '0;
        sel_busy  = 1'b0;
        launch_id = '0;
        for (int unsigned c = 0; c < NumChannels; c++) begin
            if (32'(chan) == c) begin
                chan_oh[c] = 1'b1;
                sel_src    = src_q[c];
                sel_dst    = dst_q[c];
                sel_sstr   = src_stride_q[c];
                sel_dstr   = dst_stride_q[c];
                sel_reps   = reps_q[c];
                sel_user   = user_q[c];
                sel_next   = next_id_q[c];
                sel_comp   = completed_id_q[c];
                sel_busy   = busy_vec[c];
            end
            if (xfer_valid_q[c]) launch_id = next_id_q[c];
        end
    end

    always_comb begin
        case (sub)
            5'd0:    stat_data = 64'(sel_comp);
            5'd1:    stat_data = 64'(sel_next);
            5'd2:    stat_data = 64'(sel_busy);
            default: stat_data = '0;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= StIdle;
            xfer_valid_q <= '0;
            xfer_src_q   <= '0;
            xfer_dst_q   <= '0;
            xfer_len_q   <= '0;
            xfer_sstr_q  <= '0;
            xfer_dstr_q  <= '0;
            xfer_reps_q  <= '0;
            xfer_user_q  <= '0;
            xfer_2d_q    <= 1'b0;
            rsp_data_q   <= '0;
            rsp_id_q     <= '0;
            rsp_error_q  <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (accept) begin
                        if (!legal) begin
                            rsp_data_q  <= '0;
                            rsp_error_q <= 1'b1;
                            rsp_id_q    <= acc_req_id_i;
                            state_q     <= StResp;
                        end else if (funct7 == FnCpyi || funct7 == FnCpy) begin
                            xfer_valid_q <= chan_oh;
                            xfer_src_q   <= sel_src;
                            xfer_dst_q   <= sel_dst;
                            xfer_len_q   <= acc_req_arga_i;
                            xfer_sstr_q  <= sel_sstr;
                            xfer_dstr_q  <= sel_dstr;
                            xfer_reps_q  <= sel_reps;
                            xfer_user_q  <= sel_user;
                            xfer_2d_q    <= sub[1];
                            rsp_id_q     <= acc_req_id_i;
                            state_q      <= StLaunch;
                        end else if (funct7 == FnStati || funct7 == FnStat) begin
                            rsp_data_q  <= stat_data;
                            rsp_error_q <= 1'b0;
                            rsp_id_q    <= acc_req_id_i;
                            state_q     <= StResp;
                        end
                    end
                end
                StLaunch: begin
                    if (launch_fire) begin
                        xfer_valid_q <= '0;
                        rsp_data_q   <= 64'(launch_id);
                        rsp_error_q  <= 1'b0;
                        state_q      <= StResp;
                    end
                end
                StResp: begin
                    if (acc_rsp_ready_i) state_q <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int unsigned c = 0; c < NumChannels; c++) begin
                src_q[c]          <= '0;
                dst_q[c]          <= '0;
                src_stride_q[c]   <= '0;
                dst_stride_q[c]   <= '0;
                reps_q[c]         <= '0;
                user_q[c]         <= '0;
                next_id_q[c]      <= '0;
                completed_id_q[c] <= '0;
            end
        end else begin
            for (int unsigned c = 0; c < NumChannels; c++) begin
                if (accept && legal && chan_oh[c]) begin
                    case (funct7)
                        FnSrc: src_q[c] <= AddrWidth'({acc_req_argb_i[31:0], acc_req_arga_i[31:0]});
                        FnDst: dst_q[c] <= AddrWidth'({acc_req_argb_i[31:0], acc_req_arga_i[31:0]});
                        FnStr: begin
                            src_stride_q[c] <= acc_req_arga_i;
                            dst_stride_q[c] <= acc_req_argb_i;
                        end
                        FnRep:   reps_q[c] <= acc_req_arga_i;
                        FnUser:  user_q[c] <= acc_req_arga_i;
                        default: ;
                    endcase
                end
                if (launch_fire && xfer_valid_q[c]) next_id_q[c] <= next_id_q[c] + IdWidth'(1);
                // Completion is judged against the pre-launch count, so a done with nothing
                // outstanding is dropped even if a launch lands in the same cycle.
                if (done_i[c] && busy_vec[c]) begin
                    completed_id_q[c] <= completed_id_q[c] + IdWidth'(1);
                end
            end
        end
    end

    assign acc_req_ready_o   = (state_q == StIdle);
    assign acc_rsp_valid_o   = (state_q == StResp);
    assign acc_rsp_data_o    = rsp_data_q;
    assign acc_rsp_id_o      = rsp_id_q;
    assign acc_rsp_error_o   = rsp_error_q;
    assign xfer_valid_o      = xfer_valid_q;
    assign xfer_src_o        = xfer_src_q;
    assign xfer_dst_o        = xfer_dst_q;
    assign xfer_len_o        = xfer_len_q;
    assign xfer_src_stride_o = xfer_sstr_q;
    assign xfer_dst_stride_o = xfer_dstr_q;
    assign xfer_reps_o       = xfer_reps_q;
    assign xfer_user_o       = xfer_user_q;
    assign xfer_2d_o         = xfer_2d_q;
    assign busy_o            = |busy_vec;

endmodule

// File: tb/tb_idma_inst64_chan_decoder.sv
// Bench for idma_inst64_chan_decoder: directed scenarios then a randomized instruction mix,
// checked against a per-channel behavioural model of configuration and ID counters.
module tb_idma_inst64_chan_decoder;
    localparam int unsigned AW     = 48;
    localparam int unsigned NC     = 2;
    localparam int unsigned IW     = 4;
    localparam int unsigned IdMask = (1 << IW) - 1;

    logic          clk_i = 1'b0;
    logic          rst_ni = 1'b0;
    logic          acc_req_valid_i, acc_req_ready_o;
    logic [31:0]   acc_req_op_i;
    logic [63:0]   acc_req_arga_i, acc_req_argb_i;
    logic [4:0]    acc_req_id_i;
    logic          acc_rsp_valid_o, acc_rsp_ready_i;
    logic [63:0]   acc_rsp_data_o;
    logic [4:0]    acc_rsp_id_o;
    logic          acc_rsp_error_o;
    logic [NC-1:0] xfer_valid_o, xfer_ready_i, done_i;
    logic [AW-1:0] xfer_src_o, xfer_dst_o;
    logic [63:0]   xfer_len_o, xfer_src_stride_o, xfer_dst_stride_o, xfer_reps_o, xfer_user_o;
    logic          xfer_2d_o, busy_o;

    int vectors = 0;
    int miscompares = 0;

    logic [AW-1:0] m_src [NC];
    logic [AW-1:0] m_dst [NC];
    logic [63:0]   m_sstr [NC];
    logic [63:0]   m_dstr [NC];
    logic [63:0]   m_reps [NC];
    logic [63:0]   m_user [NC];
    int unsigned   m_next [NC];
    int unsigned   m_comp [NC];
    int unsigned   cfg_fns [5];

    always #5 clk_i = ~clk_i;

    idma_inst64_chan_decoder #(
        .AddrWidth  (AW),
        .NumChannels(NC),
        .IdWidth    (IW)
    ) dut (
        .clk_i            (clk_i),
        .rst_ni           (rst_ni),
        .acc_req_valid_i  (acc_req_valid_i),
        .acc_req_ready_o  (acc_req_ready_o),
        .acc_req_op_i     (acc_req_op_i),
        .acc_req_arga_i   (acc_req_arga_i),
        .acc_req_argb_i   (acc_req_argb_i),
        .acc_req_id_i     (acc_req_id_i),
        .acc_rsp_valid_o  (acc_rsp_valid_o),
        .acc_rsp_ready_i  (acc_rsp_ready_i),
        .acc_rsp_data_o   (acc_rsp_data_o),
        .acc_rsp_id_o     (acc_rsp_id_o),
        .acc_rsp_error_o  (acc_rsp_error_o),
        .xfer_valid_o     (xfer_valid_o),
        .xfer_ready_i     (xfer_ready_i),
        .xfer_src_o       (xfer_src_o),
        .xfer_dst_o       (xfer_dst_o),
        .xfer_len_o       (xfer_len_o),
        .xfer_src_stride_o(xfer_src_stride_o),
        .xfer_dst_stride_o(xfer_dst_stride_o),
        .xfer_reps_o      (xfer_reps_o),
        .xfer_user_o      (xfer_user_o),
        .xfer_2d_o        (xfer_2d_o),
        .done_i           (done_i),
        .busy_o           (busy_o)
    );

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] enc(input int unsigned f7, input int unsigned ch,
                                        input int unsigned imm);
        enc = {7'(f7), 5'(imm), 5'd0, 3'(ch), 5'd0, 7'b0101011};
    endfunction

    function automatic bit m_busy_ch(input int unsigned c);
        return ((m_next[c] - m_comp[c]) & IdMask) != 0;
    endfunction

    function automatic bit m_busy();
        bit b = 1'b0;
        for (int unsigned c = 0; c < NC; c++) b |= m_busy_ch(c);
        return b;
    endfunction

    task automatic m_done(input logic [NC-1:0] mask);
        for (int unsigned c = 0; c < NC; c++) begin
            if (mask[c] && m_busy_ch(c)) m_comp[c] = (m_comp[c] + 1) & IdMask;
        end
    endtask

    task automatic m_reset();
        for (int unsigned c = 0; c < NC; c++) begin
            m_src[c] = '0; m_dst[c] = '0; m_sstr[c] = '0; m_dstr[c] = '0;
            m_reps[c] = '0; m_user[c] = '0; m_next[c] = 0; m_comp[c] = 0;
        end
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_req_ready"}, acc_req_ready_o, 1'b1);
        chk({tag, "_rsp_valid"}, acc_rsp_valid_o, 1'b0);
        chk({tag, "_rsp_data"}, acc_rsp_data_o, '0);
        chk({tag, "_rsp_id"}, acc_rsp_id_o, '0);
        chk({tag, "_rsp_error"}, acc_rsp_error_o, 1'b0);
        chk({tag, "_xfer_valid"}, xfer_valid_o, '0);
        chk({tag, "_src"}, xfer_src_o, '0);
        chk({tag, "_dst"}, xfer_dst_o, '0);
        chk({tag, "_len"}, xfer_len_o, '0);
        chk({tag, "_strides"}, xfer_src_stride_o | xfer_dst_stride_o, '0);
        chk({tag, "_reps_user"}, xfer_reps_o | xfer_user_o, '0);
        chk({tag, "_2d"}, xfer_2d_o, 1'b0);
        chk({tag, "_busy"}, busy_o, 1'b0);
    endtask

    task automatic do_reset();
        rst_ni = 1'b0;
        #1;
        chk_reset("in_reset");
        step();
        rst_ni = 1'b1;
        m_reset();
        step();
        chk_reset("post_reset");
    endtask

    task automatic pulse_done(input logic [NC-1:0] mask);
        done_i = mask;
        m_done(mask);
        step();
        done_i = '0;
        chk("done_busy", busy_o, m_busy());
    endtask

    // Issue one instruction; dmask pulses done_i in the accept cycle, hold delays xfer_ready_i,
    // xdmask pulses done_i in the launch handshake cycle.
    task automatic do_instr(input logic [31:0] op, input logic [63:0] a, input logic [63:0] b,
                            input logic [4:0] tag, input logic [NC-1:0] dmask, input int hold,
                            input logic [NC-1:0] xdmask);
        int unsigned   f7, ch;
        bit            legal, is_copy, is_resp;
        logic [4:0]    cfg;
        logic [63:0]   exp_data;
        logic [NC-1:0] oh;
        f7       = 32'(op[31:25]);
        ch       = 32'(op[14:12]);
        legal    = (op[6:0] == 7'b0101011) && (f7 <= 8) && (ch < NC);
        is_copy  = legal && (f7 == 2 || f7 == 3);
        is_resp  = !legal || f7 == 4 || f7 == 5;
        cfg      = (f7 == 2 || f7 == 4) ? op[24:20] : b[4:0];
        exp_data = '0;
        chk("req_ready_before", acc_req_ready_o, 1'b1);
        if (legal) begin
            case (f7)
                0: m_src[ch] = AW'({b[31:0], a[31:0]});
                1: m_dst[ch] = AW'({b[31:0], a[31:0]});
                4, 5: exp_data = (cfg == 0) ? 64'(m_comp[ch]) : (cfg == 1) ? 64'(m_next[ch]) :
                                 (cfg == 2) ? 64'(m_busy_ch(ch)) : 64'd0;
                6: begin m_sstr[ch] = a; m_dstr[ch] = b; end
                7: m_reps[ch] = a;
                8: m_user[ch] = a;
                default: ;
            endcase
        end
        acc_req_valid_i = 1'b1;
        acc_req_op_i    = op;
        acc_req_arga_i  = a;
        acc_req_argb_i  = b;
        acc_req_id_i    = tag;
        done_i          = dmask;
        m_done(dmask);
        step();
        acc_req_valid_i = 1'b0;
        done_i          = '0;
        if (is_copy) begin
            oh = NC'(1) << ch;
            for (int i = 0; i <= hold; i++) begin
                chk("xfer_valid", xfer_valid_o, oh);
                chk("xfer_src", xfer_src_o, m_src[ch]);
                chk("xfer_dst", xfer_dst_o, m_dst[ch]);
                chk("xfer_len", xfer_len_o, a);
                chk("xfer_sstr", xfer_src_stride_o, m_sstr[ch]);
                chk("xfer_dstr", xfer_dst_stride_o, m_dstr[ch]);
                chk("xfer_reps", xfer_reps_o, m_reps[ch]);
                chk("xfer_user", xfer_user_o, m_user[ch]);
                chk("xfer_2d", xfer_2d_o, cfg[1]);
                chk("req_ready_launch", acc_req_ready_o, 1'b0);
                chk("rsp_valid_launch", acc_rsp_valid_o, 1'b0);
                if (i < hold) begin
                    xfer_ready_i = ~oh;
                    step();
                end
            end
            xfer_ready_i = oh | NC'($urandom);
            done_i       = xdmask;
            exp_data     = 64'(m_next[ch]);
            m_done(xdmask);
            m_next[ch]   = (m_next[ch] + 1) & IdMask;
            step();
            xfer_ready_i = '0;
            done_i       = '0;
        end
        if (is_resp || is_copy) begin
            chk("rsp_valid", acc_rsp_valid_o, 1'b1);
            chk("rsp_data", acc_rsp_data_o, exp_data);
            chk("rsp_error", acc_rsp_error_o, !legal);
            chk("rsp_id", acc_rsp_id_o, tag);
            chk("rsp_xfer_idle", xfer_valid_o, '0);
            chk("rsp_req_ready", acc_req_ready_o, 1'b0);
            repeat ($urandom_range(0, 2)) begin
                step();
                chk("rsp_hold", acc_rsp_valid_o, 1'b1);
            end
            acc_rsp_ready_i = 1'b1;
            step();
            acc_rsp_ready_i = 1'b0;
        end
        chk("rsp_valid_after", acc_rsp_valid_o, 1'b0);
        chk("req_ready_after", acc_req_ready_o, 1'b1);
        chk("busy", busy_o, m_busy());
    endtask

    initial begin
        int unsigned   kind, ch, f7, imm;
        logic [63:0]   a, b;
        logic [31:0]   op;
        logic [NC-1:0] dm;

        acc_req_valid_i = 1'b0; acc_req_op_i = '0; acc_req_arga_i = '0; acc_req_argb_i = '0;
        acc_req_id_i = '0; acc_rsp_ready_i = 1'b0; xfer_ready_i = '0; done_i = '0;
        cfg_fns[0] = 0; cfg_fns[1] = 1; cfg_fns[2] = 6; cfg_fns[3] = 7; cfg_fns[4] = 8;
        m_reset();
        repeat (2) step();
        chk_reset("in_reset");
        rst_ni = 1'b1;
        step();
        chk_reset("post_reset");

        // Basic copy on channel 1
        do_instr(enc(0, 1, 0), 64'h1000, 64'h0, 5'd1, '0, 0, '0);
        do_instr(enc(1, 1, 0), 64'h2000, 64'h0, 5'd2, '0, 0, '0);
        do_instr(enc(2, 1, 0), 64'd64, 64'h0, 5'd3, '0, 0, '0);
        do_instr(enc(4, 1, 1), 64'h0, 64'h0, 5'd4, '0, 0, '0);
        // 2-D copy on channel 0 with strides and reps, ready held off for 5 cycles
        do_instr(enc(6, 0, 0), 64'd8, 64'd16, 5'd5, '0, 0, '0);
        do_instr(enc(7, 0, 0), 64'd4, 64'h0, 5'd6, '0, 0, '0);
        do_instr(enc(3, 0, 0), 64'd256, 64'd2, 5'd7, '0, 5, '0);
        chk("s035_2d", xfer_2d_o, 1'b1);
        // Busy read racing the completion of the last transfer
        pulse_done(2'b10);
        do_instr(enc(4, 0, 2), 64'h0, 64'h0, 5'd8, 2'b01, 0, '0);
        do_instr(enc(4, 0, 2), 64'h0, 64'h0, 5'd9, '0, 0, '0);
        // Out-of-range channel
        do_instr(enc(2, 3, 0), 64'd32, 64'h0, 5'd10, '0, 0, '0);

        // ID wrap: next_id reaches all-ones with one transfer outstanding, then launches again
        do_reset();
        for (int i = 0; i < 15; i++) begin
            do_instr(enc(2, 0, 0), 64'(i), 64'h0, 5'(i), '0, 0, '0);
            if (i < 14) pulse_done(2'b01);
        end
        do_instr(enc(4, 0, 1), 64'h0, 64'h0, 5'd20, '0, 0, '0);
        do_instr(enc(2, 0, 0), 64'd99, 64'h0, 5'd21, '0, 0, '0);
        chk("wrap_busy", busy_o, 1'b1);
        do_instr(enc(4, 0, 1), 64'h0, 64'h0, 5'd22, '0, 0, '0);
        do_instr(enc(4, 0, 2), 64'h0, 64'h0, 5'd23, '0, 0, '0);

        // Reset while a launch is pending aborts it without a response
        do_instr(enc(0, 0, 0), 64'h1234, 64'h5678, 5'd24, '0, 0, '0);
        acc_req_valid_i = 1'b1;
        acc_req_op_i    = enc(2, 0, 0);
        acc_req_arga_i  = 64'd7;
        step();
        acc_req_valid_i = 1'b0;
        chk("abort_pending", xfer_valid_o, 2'b01);
        do_reset();
        do_instr(enc(4, 0, 1), 64'h0, 64'h0, 5'd25, '0, 0, '0);
        do_instr(enc(2, 0, 0), 64'd5, 64'h0, 5'd26, '0, 0, '0);

        // Randomized mix
        for (int n = 0; n < 300; n++) begin
            kind = $urandom_range(0, 9);
            ch   = ($urandom_range(0, 7) == 0) ? $urandom_range(2, 7) : $urandom_range(0, 1);
            a    = {$urandom, $urandom};
            b    = {$urandom, $urandom};
            imm  = $urandom_range(0, 31);
            dm   = ($urandom_range(0, 3) == 0) ? NC'($urandom) : '0;
            case (kind)
                0, 1, 2, 3: f7 = cfg_fns[$urandom_range(0, 4)];
                4, 5:       f7 = 2 + $urandom_range(0, 1);
                6, 7: begin
                    f7  = 4 + $urandom_range(0, 1);
                    imm = $urandom_range(0, 3);
                    b   = {b[63:5], 5'($urandom_range(0, 3))};
                end
                default:    f7 = $urandom_range(9, 127);
            endcase
            op = enc(f7, ch, imm);
            if (kind == 8 && $urandom_range(0, 1) == 1) op = op ^ 32'h1;
            if (kind == 9) begin
                pulse_done(NC'($urandom));
            end else begin
                do_instr(op, a, b, 5'($urandom), dm, $urandom_range(0, 3),
                         ($urandom_range(0, 2) == 0) ? NC'($urandom) : '0);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/idma_inst64_chan_decoder.md
IDMA_INST64_CHAN_DECODER -- requirements
Module: idma_inst64_chan_decoder

Interface
REQ-001 SHALL have parameter AddrWidth, default 48: width of source and destination addresses.
REQ-002 SHALL have parameter NumChannels, default 2, range 1..8: number of independent DMA channels.
REQ-003 SHALL have parameter IdWidth, default 32: width of the transfer-ID counters.
REQ-004 SHALL have port clk_i, input, 1: the single clock.
REQ-005 SHALL have port rst_ni, input, 1: reset, asynchronous, active-low.
REQ-006 SHALL have port acc_req_valid_i / acc_req_ready_o, in/out, 1 each: instruction handshake.
REQ-007 SHALL have port acc_req_op_i, input, 32: instruction word.
REQ-008 SHALL have ports acc_req_arga_i / acc_req_argb_i, input, 64 each: rs1 / rs2 operands.
REQ-009 SHALL have port acc_req_id_i, input, 5: destination register tag.
REQ-010 SHALL have ports acc_rsp_valid_o / acc_rsp_ready_i, out/in, 1 each: response handshake.
REQ-011 SHALL have ports acc_rsp_data_o (out, 64), acc_rsp_id_o (out, 5) and acc_rsp_error_o (out, 1).
REQ-012 SHALL have ports xfer_valid_o / xfer_ready_i, out/in, NumChannels each: one-hot transfer launch.
REQ-013 SHALL have shared transfer payload outputs xfer_src_o / xfer_dst_o (AddrWidth), xfer_len_o, xfer_src_stride_o, xfer_dst_stride_o, xfer_reps_o and xfer_user_o (64 each), and xfer_2d_o (1).
REQ-014 SHALL have port done_i, input, NumChannels: one-cycle completion pulse per channel.
REQ-015 SHALL have port busy_o, input-independent output, 1: OR over all channels of outstanding != 0.

Function
REQ-016 SHALL decode instructions with op[6:0]=0101011 by funct7 op[31:25]: 0 DMSRC, 1 DMDST, 2 DMCPYI, 3 DMCPY, 4 DMSTATI, 5 DMSTAT, 6 DMSTR, 7 DMREP, 8 DMUSER.
REQ-017 SHALL select the channel from op[14:12]; a channel >= NumChannels, a wrong opcode or an unknown funct7 SHALL produce an error response (data 0, error 1) and change no state.
REQ-018 SHALL hold per-channel configuration registers: src, dst, src_stride, dst_stride, reps and user.
REQ-019 DMSRC/DMDST SHALL write {argb[31:0], arga[31:0]}, truncated to AddrWidth, to src/dst.
REQ-020 DMSTR SHALL write src_stride=arga and dst_stride=argb; DMREP SHALL write reps=arga; DMUSER SHALL write user=arga.
REQ-021 Configuration writes SHALL complete in the accept cycle and SHALL produce no response.
REQ-022 FSM states SHALL be IDLE, LAUNCH and RESP; acc_req_ready_o SHALL be 1 only in IDLE.
REQ-023 DMCPYI/DMCPY SHALL take IDLE->LAUNCH, with len=arga and cfg=op[24:20] for DMCPYI or argb[4:0] for DMCPY; xfer_2d_o SHALL be cfg[1].
REQ-024 In LAUNCH, only the selected channel's xfer_valid_o bit SHALL be 1, with the payload registered and stable; on xfer_ready_i the FSM SHALL go to RESP with data = that channel's next_id and next_id++.
REQ-025 DMSTATI/DMSTAT SHALL take IDLE->RESP with field = op[24:20] (DMSTATI) or argb[4:0] (DMSTAT): 0 completed_id, 1 next_id, 2 busy (outstanding != 0), others 0; data SHALL be zero-extended and sampled at accept.
REQ-026 In RESP, acc_rsp_valid_o SHALL be 1 and acc_rsp_id_o SHALL equal the captured tag; on acc_rsp_ready_i the FSM SHALL go to IDLE; a new instruction SHALL be accepted earliest the following cycle.
REQ-027 done_i[c] SHALL increment completed_id[c]; a launch and a completion on the same channel in the same cycle SHALL both take effect.
REQ-028 Counters SHALL wrap modulo 2^IdWidth; outstanding SHALL be next_id - completed_id, computed modulo 2^IdWidth.
REQ-029 done_i on a channel with outstanding == 0 SHALL be ignored.
REQ-030 Latency SHALL be: config write 1 cycle; status response valid 1 cycle after accept; copy response valid 1 cycle after xfer handshake.

Reset
REQ-031 On rst_ni low, state SHALL go to IDLE and all configuration registers and counters SHALL be 0.
REQ-032 During and after reset, all valid outputs, payloads, response data, error, id and busy_o SHALL be 0, and acc_req_ready_o SHALL be 1.
REQ-033 Reset asserted in LAUNCH or RESP SHALL abort the pending operation with no response issued.

Verification
REQ-034 Scenario: write DMSRC 0x1000, DMDST 0x2000 and DMCPYI len 64 cfg 0 on ch1 -> xfer_valid_o=2'b10, src 0x1000, dst 0x2000, len 64, 2d 0; response data 0; next_id[1]=1.
REQ-035 Scenario: DMSTR (8,16), DMREP 4, then DMCPY with argb=2 -> xfer_2d_o=1, strides 8/16, reps 4.
REQ-036 Scenario: hold xfer_ready_i low for 5 cycles -> payload stable and acc_req_ready_o=0 throughout.
REQ-037 Scenario: DMSTATI field 2 issued in the same cycle as the done_i that clears the last transfer -> response 1; the next DMSTATI returns 0.
REQ-038 Scenario: op[14:12]=3 with NumChannels=2 -> error=1, data 0, no xfer_valid_o.
REQ-039 Scenario: next_id=2^IdWidth-1 followed by one launch -> next_id 0 and busy_o remains 1.
